// File: rtl/csr_pkg.sv
// Shared machine-CSR definitions: CSR numbers, mstatus fields, mtvec modes, sequencer states.
// Also holds the mstatus transforms applied on trap entry and on MRET.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [3:0] {
    IDLE,
    T_RD_STATUS,
    T_WAIT_STATUS,
    T_WR_MEPC,
    T_WR_MCAUSE,
    T_WR_STATUS,
    T_RD_MTVEC,
    T_WAIT_MTVEC,
    M_RD_STATUS,
    M_WAIT_STATUS,
    M_WR_STATUS,
    M_RD_MEPC,
    M_WAIT_MEPC,
    REDIRECT
  } seq_state_e;

  function automatic logic [31:0] trap_status(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return r;
  endfunction

  // Only M-mode exists, so MPP is reloaded with M rather than cleared to U.
  function automatic logic [31:0] mret_status(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
    return r;
  endfunction

endpackage

// File: rtl/trap_vector_calc.sv
// Trap target from mtvec and mcause: vectored mode offsets interrupts by 4*cause, all else jumps to base.
// Purely combinational, no handshake.
module trap_vector_calc
  import csr_pkg::*;
(
  input  logic [31:0] mtvec,
  input  logic [31:0] cause,
  output logic [31:0] pc
);

  logic [31:0] base;
  logic        unused_cause;

  assign base         = {mtvec[31:2], 2'b00};
  assign unused_cause = cause[30];

  always_comb begin
    pc = base;
    if (mtvec[1:0] == MTVEC_VECTORED && cause[31]) begin
      pc = base + {cause[29:0], 2'b00};
    end
  end

endmodule

// File: rtl/csr_trap_seq.sv
// Trap-entry / MRET sequencer driving the machine CSR port; redirect 8 cycles (trap) or 6 (MRET) after accept.
// Requests are held by the requester and acked only from IDLE; requests seen while busy are ignored.
module csr_trap_seq
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic        mret_req_i,
  output logic        trap_ack_o,
  output logic        mret_ack_o,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] csr_address_o,
  output logic        csr_en_write_o,
  output logic        csr_en_read_o,
  output logic [31:0] csr_data_o,
  input  logic [31:0] csr_data_i
);

  seq_state_e  state_q, state_d;
  logic [31:0] cause_q, pc_q, status_q, redirect_pc_q;
  logic [31:0] vector_pc;
  logic [11:0] csr_addr;

  trap_vector_calc u_vector (
    .mtvec (csr_data_i),
    .cause (cause_q),
    .pc    (vector_pc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cause_q       <= '0;
      pc_q          <= '0;
      status_q      <= '0;
      redirect_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && trap_req_i) begin
        cause_q <= trap_cause_i;
        pc_q    <= trap_pc_i;
      end
      if (state_q == T_WAIT_STATUS || state_q == M_WAIT_STATUS) begin
        status_q <= csr_data_i;
      end
      if (state_q == T_WAIT_MTVEC) begin
        redirect_pc_q <= vector_pc;
      end
      if (state_q == M_WAIT_MEPC) begin
        redirect_pc_q <= {csr_data_i[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trap_req_i) begin
          state_d = T_RD_STATUS;
        end else if (mret_req_i) begin
          state_d = M_RD_STATUS;
        end
      end
      T_RD_STATUS:   state_d = T_WAIT_STATUS;
      T_WAIT_STATUS: state_d = T_WR_MEPC;
      T_WR_MEPC:     state_d = T_WR_MCAUSE;
      T_WR_MCAUSE:   state_d = T_WR_STATUS;
      T_WR_STATUS:   state_d = T_RD_MTVEC;
      T_RD_MTVEC:    state_d = T_WAIT_MTVEC;
      T_WAIT_MTVEC:  state_d = REDIRECT;
      M_RD_STATUS:   state_d = M_WAIT_STATUS;
      M_WAIT_STATUS: state_d = M_WR_STATUS;
      M_WR_STATUS:   state_d = M_RD_MEPC;
      M_RD_MEPC:     state_d = M_WAIT_MEPC;
      M_WAIT_MEPC:   state_d = REDIRECT;
      REDIRECT:      state_d = IDLE;
      default:       state_d = IDLE;
    endcase
  end

  // Wait states keep presenting the read address while the CSR file returns data.
  always_comb begin
    trap_ack_o       = 1'b0;
    mret_ack_o       = 1'b0;
    redirect_valid_o = 1'b0;
    csr_en_read_o    = 1'b0;
    csr_en_write_o   = 1'b0;
    csr_addr         = 12'h000;
    csr_data_o       = '0;
    case (state_q)
      T_RD_STATUS: begin
        trap_ack_o    = 1'b1;
        csr_en_read_o = 1'b1;
        csr_addr      = CSR_MSTATUS;
      end
      T_WAIT_STATUS: csr_addr = CSR_MSTATUS;
      T_WR_MEPC: begin
        csr_en_write_o = 1'b1;
        csr_addr       = CSR_MEPC;
        csr_data_o     = pc_q;
      end
      T_WR_MCAUSE: begin
        csr_en_write_o = 1'b1;
        csr_addr       = CSR_MCAUSE;
        csr_data_o     = cause_q;
      end
      T_WR_STATUS: begin
        csr_en_write_o = 1'b1;
        csr_addr       = CSR_MSTATUS;
        csr_data_o     = trap_status(status_q);
      end
      T_RD_MTVEC: begin
        csr_en_read_o = 1'b1;
        csr_addr      = CSR_MTVEC;
      end
      T_WAIT_MTVEC: csr_addr = CSR_MTVEC;
      M_RD_STATUS: begin
        mret_ack_o    = 1'b1;
        csr_en_read_o = 1'b1;
        csr_addr      = CSR_MSTATUS;
      end
      M_WAIT_STATUS: csr_addr = CSR_MSTATUS;
      M_WR_STATUS: begin
        csr_en_write_o = 1'b1;
        csr_addr       = CSR_MSTATUS;
        csr_data_o     = mret_status(status_q);
      end
      M_RD_MEPC: begin
        csr_en_read_o = 1'b1;
        csr_addr      = CSR_MEPC;
      end
      M_WAIT_MEPC: csr_addr = CSR_MEPC;
      REDIRECT:    redirect_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign csr_address_o = {20'h00000, csr_addr};
  assign busy_o        = (state_q != IDLE);
  assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed bench for csr_trap_seq with a small registered-read CSR file model behind the CSR port.
// Vector table covers trap/MRET variants; hand sequences cover priority, busy requests and mid-sequence reset.
module tb_csr_trap_seq;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trap_req_i, mret_req_i;
  logic [31:0] trap_cause_i, trap_pc_i;
  logic        trap_ack_o, mret_ack_o, busy_o, redirect_valid_o;
  logic [31:0] redirect_pc_o, csr_address_o, csr_data_o, csr_data_i;
  logic        csr_en_write_o, csr_en_read_o;

  csr_trap_seq #(.RESET_PC(RST_PC)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .trap_req_i       (trap_req_i),
    .trap_cause_i     (trap_cause_i),
    .trap_pc_i        (trap_pc_i),
    .mret_req_i       (mret_req_i),
    .trap_ack_o       (trap_ack_o),
    .mret_ack_o       (mret_ack_o),
    .busy_o           (busy_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .csr_address_o    (csr_address_o),
    .csr_en_write_o   (csr_en_write_o),
    .csr_en_read_o    (csr_en_read_o),
    .csr_data_o       (csr_data_o),
    .csr_data_i       (csr_data_i)
  );

  always #5 clk_i = ~clk_i;

  // CSR file model: registered read data, writes on the clock edge, preload via ld.
  logic        ld;
  logic [31:0] ld_status, ld_tvec, ld_epc, ld_cause;
  logic [31:0] m_status, m_tvec, m_epc, m_cause, rd_q;
  int          wr_cause_cnt;

  always @(posedge clk_i) begin
    if (ld) begin
      m_status     <= ld_status;
      m_tvec       <= ld_tvec;
      m_epc        <= ld_epc;
      m_cause      <= ld_cause;
      wr_cause_cnt <= 0;
    end else if (csr_en_write_o) begin
      case (csr_address_o)
        32'h300: m_status <= csr_data_o;
        32'h305: m_tvec   <= csr_data_o;
        32'h341: m_epc    <= csr_data_o;
        32'h342: begin
          m_cause      <= csr_data_o;
          wr_cause_cnt <= wr_cause_cnt + 1;
        end
        default: ;
      endcase
    end
    if (csr_en_read_o) begin
      case (csr_address_o)
        32'h300: rd_q <= m_status;
        32'h305: rd_q <= m_tvec;
        32'h341: rd_q <= m_epc;
        32'h342: rd_q <= m_cause;
        default: rd_q <= 32'h0;
      endcase
    end
  end
  assign csr_data_i = rd_q;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_trap;
    logic [31:0] cause, pc;
    logic [31:0] i_status, i_tvec, i_epc, i_cause;
    logic [31:0] e_status, e_epc, e_cause, e_pc;
  } vec_t;

  vec_t        vecs[7];
  logic [13:0] trap_tr[0:8];
  logic [13:0] mret_tr[0:6];

  task automatic load_model(input logic [31:0] s, input logic [31:0] t, input logic [31:0] e, input logic [31:0] c);
    ld_status = s; ld_tvec = t; ld_epc = e; ld_cause = c;
    ld = 1'b1;
    @(posedge clk_i); #1;
    ld = 1'b0;
  endtask

  // Raise a request from IDLE, follow it to the redirect pulse, checking per-cycle strobes and latency.
  task automatic run_req(input logic is_trap, input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] exp_pc, input string tag);
    int cyc;
    int exp_lat;
    logic done;
    logic [13:0] obs, exp_tr;
    exp_lat = is_trap ? 8 : 6;
    trap_cause_i = cause;
    trap_pc_i    = pc;
    if (is_trap) trap_req_i = 1'b1; else mret_req_i = 1'b1;
    cyc  = 0;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(posedge clk_i); #1;
      if (cyc == 0) begin
        if (is_trap ? trap_ack_o : mret_ack_o) begin
          cyc = 1;
          trap_req_i = 1'b0;
          mret_req_i = 1'b0;
        end
      end else begin
        cyc++;
      end
      if (cyc >= 1 && cyc <= exp_lat) begin
        obs = {csr_en_read_o, csr_en_write_o,
               (csr_en_read_o | csr_en_write_o) ? csr_address_o[11:0] : 12'h000};
        exp_tr = is_trap ? trap_tr[cyc] : mret_tr[cyc];
        check($sformatf("%s_strobe_c%0d", tag, cyc), {18'h0, obs}, {18'h0, exp_tr});
      end
      if (redirect_valid_o) done = 1'b1;
    end
    trap_req_i = 1'b0;
    mret_req_i = 1'b0;
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_redirect_pc"}, redirect_pc_o, exp_pc);
    @(posedge clk_i); #1;
    check({tag, "_pulse_end"}, {30'h0, redirect_valid_o, busy_o}, 32'h0);
    check({tag, "_pc_hold"}, redirect_pc_o, exp_pc);
  endtask

  initial begin
    int guard;
    int mret_ack_seen;
    trap_tr[0] = 14'h0000; trap_tr[1] = 14'h2300; trap_tr[2] = 14'h0000;
    trap_tr[3] = 14'h1341; trap_tr[4] = 14'h1342; trap_tr[5] = 14'h1300;
    trap_tr[6] = 14'h2305; trap_tr[7] = 14'h0000; trap_tr[8] = 14'h0000;
    mret_tr[0] = 14'h0000; mret_tr[1] = 14'h2300; mret_tr[2] = 14'h0000;
    mret_tr[3] = 14'h1300; mret_tr[4] = 14'h2341; mret_tr[5] = 14'h0000;
    mret_tr[6] = 14'h0000;

    //          trap  cause         pc            status        mtvec         mepc          mcause        e_status      e_mepc        e_mcause      e_pc
    vecs[0] = '{1'b1, 32'h0000_0002, 32'h0000_0200, 32'h0000_0008, 32'h0000_1000, 32'h0, 32'h0, 32'h0000_1880, 32'h0000_0200, 32'h0000_0002, 32'h0000_1000};
    vecs[1] = '{1'b1, 32'h8000_0007, 32'h0000_0344, 32'h0000_0088, 32'h0000_1001, 32'h0, 32'h0, 32'h0000_1880, 32'h0000_0344, 32'h8000_0007, 32'h0000_101C};
    vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_0400, 32'h0000_0000, 32'h0000_1001, 32'h0, 32'h0, 32'h0000_1800, 32'h0000_0400, 32'h0000_0005, 32'h0000_1000};
    vecs[3] = '{1'b0, 32'h0,         32'h0,         32'h0000_1880, 32'h0000_1000, 32'h0000_0206, 32'h5, 32'h0000_1888, 32'h0000_0206, 32'h0000_0005, 32'h0000_0204};
    vecs[4] = '{1'b1, 32'h8000_0003, 32'h0000_0010, 32'h0000_1808, 32'h0000_2003, 32'h0, 32'h0, 32'h0000_1880, 32'h0000_0010, 32'h8000_0003, 32'h0000_2000};
    vecs[5] = '{1'b1, 32'h8000_0007, 32'h0000_0020, 32'h0000_0000, 32'hFFFF_FFF1, 32'h0, 32'h0, 32'h0000_1800, 32'h0000_0020, 32'h8000_0007, 32'h0000_000C};
    vecs[6] = '{1'b0, 32'h0,         32'h0,         32'h0000_0008, 32'h0000_1000, 32'hFFFF_FFFF, 32'h9, 32'h0000_1880, 32'hFFFF_FFFF, 32'h0000_0009, 32'hFFFF_FFFC};

    rst_i = 1'b1; trap_req_i = 1'b0; mret_req_i = 1'b0;
    trap_cause_i = 32'h0; trap_pc_i = 32'h0; ld = 1'b0;
    ld_status = 32'h0; ld_tvec = 32'h0; ld_epc = 32'h0; ld_cause = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_acks", {30'h0, trap_ack_o, mret_ack_o}, 32'h0);
    check("rst_strobes", {29'h0, csr_en_read_o, csr_en_write_o, redirect_valid_o}, 32'h0);
    check("rst_addr", csr_address_o, 32'h0);
    check("rst_wdata", csr_data_o, 32'h0);
    check("rst_pc", redirect_pc_o, RST_PC);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      load_model(vecs[i].i_status, vecs[i].i_tvec, vecs[i].i_epc, vecs[i].i_cause);
      run_req(vecs[i].is_trap, vecs[i].cause, vecs[i].pc, vecs[i].e_pc, $sformatf("v%0d", i));
      check($sformatf("v%0d_mstatus", i), m_status, vecs[i].e_status);
      check($sformatf("v%0d_mepc", i), m_epc, vecs[i].e_epc);
      check($sformatf("v%0d_mcause", i), m_cause, vecs[i].e_cause);
    end

    // Both requests together: trap wins, held MRET waits through the busy trap and starts after one idle cycle.
    load_model(32'h0000_0008, 32'h0000_1000, 32'h0, 32'h0);
    trap_cause_i = 32'h0000_0002; trap_pc_i = 32'h0000_0200;
    trap_req_i = 1'b1; mret_req_i = 1'b1;
    @(posedge clk_i); #1;
    check("both_trap_ack", {31'h0, trap_ack_o}, 32'h1);
    check("both_no_mret_ack", {31'h0, mret_ack_o}, 32'h0);
    trap_req_i = 1'b0;
    mret_ack_seen = 0;
    guard = 0;
    while (!redirect_valid_o && guard < 20) begin
      @(posedge clk_i); #1;
      if (mret_ack_o) mret_ack_seen++;
      guard++;
    end
    check("busy_trap_redirect", {31'h0, redirect_valid_o}, 32'h1);
    check("busy_mret_ignored", mret_ack_seen, 0);
    @(posedge clk_i); #1;
    check("gap_idle", {30'h0, busy_o, mret_ack_o}, 32'h0);
    @(posedge clk_i); #1;
    check("held_mret_ack", {31'h0, mret_ack_o}, 32'h1);
    mret_req_i = 1'b0;
    guard = 1;
    while (!redirect_valid_o && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    check("held_mret_latency", guard, 6);
    check("held_mret_pc", redirect_pc_o, 32'h0000_0200);
    check("held_mret_status", m_status, 32'h0000_1888);
    @(posedge clk_i); #1;

    // Reset taking effect at the edge that would enter T_WR_MCAUSE.
    load_model(32'h0000_0008, 32'h0000_1000, 32'h0, 32'h0000_1234);
    trap_cause_i = 32'h0000_0002; trap_pc_i = 32'h0000_0200;
    trap_req_i = 1'b1;
    @(posedge clk_i); #1;
    check("rstseq_ack", {31'h0, trap_ack_o}, 32'h1);
    trap_req_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("rstseq_mepc_wr", {csr_en_write_o, 19'h0, csr_address_o[11:0]}, 32'h8000_0341);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rstseq_busy", {31'h0, busy_o}, 32'h0);
    check("rstseq_strobes", {28'h0, csr_en_read_o, csr_en_write_o, redirect_valid_o, trap_ack_o}, 32'h0);
    check("rstseq_addr_data", csr_address_o | csr_data_o, 32'h0);
    check("rstseq_pc", redirect_pc_o, RST_PC);
    guard = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      if (csr_en_write_o || busy_o) guard++;
    end
    check("rstseq_quiet", guard, 0);
    check("rstseq_no_mcause_wr", wr_cause_cnt, 0);
    check("rstseq_mcause", m_cause, 32'h0000_1234);
    check("rstseq_mstatus", m_status, 32'h0000_0008);
    check("rstseq_mepc", m_epc, 32'h0000_0200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_trap_seq.md
# csr_trap_seq

Machine-mode trap and MRET sequencer. Sits directly upstream of the machine CSR register file and drives its address/write/read port. On a trap it performs the privileged-spec entry update: mepc, mcause, mstatus MIE/MPIE/MPP. It then fetches mtvec and emits a redirect PC to fetch. On MRET it restores mstatus and redirects to mepc.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value driven on redirect_pc_o while idle/reset

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- trap_req_i  in  1  trap request, held until trap_ack_o
- trap_cause_i  in  32  mcause value (bit 31 = interrupt)
- trap_pc_i  in  32  faulting/interrupted PC, written to mepc
- mret_req_i  in  1  MRET request, held until mret_ack_o
- trap_ack_o  out  1  one-cycle acceptance pulse for trap
- mret_ack_o  out  1  one-cycle acceptance pulse for MRET
- busy_o  out  1  high in every non-IDLE state
- redirect_valid_o  out  1  one-cycle pulse, redirect_pc_o valid
- redirect_pc_o  out  32  new fetch PC
- csr_address_o  out  32  CSR number, zero-extended 12-bit
- csr_en_write_o  out  1  CSR write strobe
- csr_en_read_o  out  1  CSR read strobe
- csr_data_o  out  32  CSR write data
- csr_data_i  in  32  CSR read data, registered by the CSR file

## Operation
- Integration holds the CSR file exception-mode input low. This block uses only the normal read/write path.
- Read protocol: en_read asserted one cycle (RD_x). Data is valid in the following cycle (WAIT_x) and captured at the end of it.
- States: IDLE, T_RD_STATUS, T_WAIT_STATUS, T_WR_MEPC, T_WR_MCAUSE, T_WR_STATUS, T_RD_MTVEC, T_WAIT_MTVEC, M_RD_STATUS, M_WAIT_STATUS, M_WR_STATUS, M_RD_MEPC, M_WAIT_MEPC, REDIRECT.
- IDLE: trap_req_i → T_RD_STATUS, latch cause and pc. Otherwise mret_req_i → M_RD_STATUS. Trap has priority if both are high; MRET is not acked.
- Trap path: read 0x300 → write 0x341 with latched pc → write 0x342 with latched cause.
  - Then write 0x300 with status' = status, except MPIE(7) = status[3], MIE(3) = 0, MPP(12:11) = 2'b11.
  - Then read 0x305 → REDIRECT.
- Trap vector, from mtvec[1:0]:
  - 2'b01 with cause[31] = 1: {mtvec[31:2], 2'b00} + (cause[29:0] << 2), 32-bit wrap.
  - Otherwise (modes 00/10/11, or exceptions): {mtvec[31:2], 2'b00}.
- MRET path: read 0x300 → write 0x300 with MIE = status[7], MPIE = 1, MPP = 2'b11, other bits unchanged → read 0x341 → REDIRECT with pc = {mepc[31:2], 2'b00}.
- REDIRECT: redirect_valid_o = 1 for one cycle, then IDLE.
- Requests arriving while busy are neither acked nor queued. A request still high in IDLE is a new request.

## Timing
- Reset values:
  - State IDLE.
  - All strobes, acks, busy_o, redirect_valid_o = 0.
  - csr_address_o = 0, csr_data_o = 0, redirect_pc_o = RESET_PC.
  - Latched cause/pc/status = 0.
- Reset mid-sequence aborts immediately. No further CSR writes are issued, even if partially updated.
- CSR port outputs are Moore-decoded from the state register; there are no input-to-output combinational paths.
- Acks are high in the first state after acceptance (T_RD_STATUS / M_RD_STATUS).
- Trap latency: acceptance edge E0 → redirect_valid_o high in cycle 8 (states 1-7 are the sequence).
- MRET latency: E0 → redirect_valid_o high in cycle 6.
- Back-to-back: a new request can be accepted at the edge leaving REDIRECT's following IDLE cycle, i.e. 1 idle cycle minimum between sequences.
- redirect_pc_o holds its last value after the pulse until the next REDIRECT.

## Structure
- Shared csr_pkg:
  - CSR address constants: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342.
  - mstatus bit positions: MIE, MPIE, MPP.
  - mtvec mode encodings.
  - State enumeration.
- One combinational sub-module, trap_vector_calc (mtvec, cause → pc), reused by later interrupt logic.

## Test plan
- Trap, exception: mtvec = 0x0000_1000, mstatus = 0x0000_0008, trap_req_i with cause 0x2, pc 0x0000_0200 → writes mepc = 0x200, mcause = 0x2, mstatus = 0x0000_1880; redirect 0x0000_1000 in cycle 8.
- Vectored interrupt: mtvec = 0x0000_1001, cause 0x8000_0007 → redirect 0x0000_101C. Same mtvec with cause 0x5 → 0x0000_1000.
- MRET: mstatus = 0x0000_1880, mepc = 0x0000_0206 → mstatus written 0x0000_1888, redirect 0x0000_0204 in cycle 6.
- Simultaneous trap_req_i and mret_req_i → only trap_ack_o. After completion, held mret_req_i is accepted and MRET completes.
- rst_i asserted in T_WR_MCAUSE → next cycle all outputs at reset values. mcause write absent, mstatus unchanged; busy_o = 0.
- Request during busy → no ack until IDLE. Exact strobe/address sequence per cycle checked against state list.
